// File: rtl/wb_tgt_pchk.sv
// Passive pipelined Wishbone target-side protocol checker: tracks outstanding requests,
// flags protocol violations (sticky + irq) and keeps saturating termination statistics.
module wb_tgt_pchk #(
   parameter int unsigned MAX_OUT    = 8,
   parameter int unsigned OUT_WIDTH  = 4,
   parameter int unsigned TIMEOUT    = 200,
   parameter int unsigned TO_WIDTH   = 8,
   parameter int unsigned STAT_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  sync_rst_i,
   input  logic                  tgt_cyc_o,
   input  logic                  tgt_stb_o,
   input  logic                  tgt_stall_i,
   input  logic                  tgt_ack_i,
   input  logic                  tgt_err_i,
   input  logic                  tgt_rty_i,
   input  logic                  clr_i,
   output logic [5:0]            viol_o,
   output logic                  irq_o,
   output logic [OUT_WIDTH-1:0]  outst_o,
   output logic [1:0]            state_o,
   output logic [STAT_WIDTH-1:0] ack_cnt_o,
   output logic [STAT_WIDTH-1:0] err_cnt_o,
   output logic [STAT_WIDTH-1:0] rty_cnt_o
);

   typedef enum logic [1:0] {StIdle = 2'b00, StCyc = 2'b01, StWait = 2'b10, StTout = 2'b11} state_e;

   state_e                state_q;
   logic [OUT_WIDTH-1:0]  outst_q, outst_d;
   logic [OUT_WIDTH:0]    outst_sum;
   logic [TO_WIDTH-1:0]   tmr_q, tmr_d;
   logic [5:0]            viol_q, viol_set;
   logic                  irq_q;
   logic [STAT_WIDTH-1:0] ack_cnt_q, err_cnt_q, rty_cnt_q;
   logic                  req, rsp, outst_nz, tmr_inc, tmr_hit, rsp_valid;

   function automatic logic [STAT_WIDTH-1:0] stat_next(input logic [STAT_WIDTH-1:0] cnt,
                                                       input logic inc, input logic clr);
      if (clr) return STAT_WIDTH'(inc);
      if (inc && cnt != '1) return cnt + STAT_WIDTH'(1);
      return cnt;
   endfunction

   always_comb begin
      req       = tgt_cyc_o & tgt_stb_o & ~tgt_stall_i;
      rsp       = tgt_ack_i | tgt_err_i | tgt_rty_i;
      outst_nz  = (outst_q != '0);
      rsp_valid = tgt_cyc_o & outst_nz;

      // A response only retires a request when one is actually outstanding.
      outst_sum = {1'b0, outst_q} + (OUT_WIDTH+1)'(req) - (OUT_WIDTH+1)'(rsp & outst_nz);
      if (!tgt_cyc_o) begin
         outst_d = '0;
      end else if (outst_sum > (OUT_WIDTH+1)'(MAX_OUT)) begin
         outst_d = OUT_WIDTH'(MAX_OUT);
      end else begin
         outst_d = outst_sum[OUT_WIDTH-1:0];
      end

      tmr_inc = tgt_cyc_o & ~rsp & outst_nz;
      tmr_hit = tmr_inc & (tmr_q == TO_WIDTH'(TIMEOUT - 1));
      if (!tmr_inc) begin
         tmr_d = '0;
      end else if (tmr_q == TO_WIDTH'(TIMEOUT)) begin
         tmr_d = tmr_q;
      end else begin
         tmr_d = tmr_q + TO_WIDTH'(1);
      end

      viol_set    = '0;
      viol_set[0] = (tgt_ack_i & tgt_err_i) | (tgt_ack_i & tgt_rty_i) | (tgt_err_i & tgt_rty_i);
      viol_set[1] = rsp & (~outst_nz | ~tgt_cyc_o);
      viol_set[2] = req & ~rsp & (outst_q == OUT_WIDTH'(MAX_OUT));
      viol_set[3] = ~tgt_cyc_o & outst_nz;
      viol_set[4] = tmr_hit;
      viol_set[5] = tgt_stb_o & ~tgt_cyc_o;
   end

   always_ff @(posedge clk_i) begin
      if (sync_rst_i) begin
         state_q   <= StIdle;
         outst_q   <= '0;
         tmr_q     <= '0;
         viol_q    <= '0;
         irq_q     <= 1'b0;
         ack_cnt_q <= '0;
         err_cnt_q <= '0;
         rty_cnt_q <= '0;
      end else begin
         outst_q   <= outst_d;
         tmr_q     <= tmr_d;
         // New violations win over a coincident clear.
         viol_q    <= (clr_i ? 6'b0 : viol_q) | viol_set;
         irq_q     <= |viol_q;
         ack_cnt_q <= stat_next(ack_cnt_q, tgt_ack_i & rsp_valid, clr_i);
         err_cnt_q <= stat_next(err_cnt_q, tgt_err_i & rsp_valid, clr_i);
         rty_cnt_q <= stat_next(rty_cnt_q, tgt_rty_i & rsp_valid, clr_i);
         if (!tgt_cyc_o) begin
            state_q <= StIdle;
         end else begin
            unique case (state_q)
               StIdle: state_q <= StCyc;
               StCyc:  if (req) state_q <= StWait;
               StWait: begin
                  if (outst_d == '0) state_q <= StCyc;
                  else if (tmr_hit)  state_q <= StTout;
               end
               StTout: if (rsp) state_q <= (outst_d != '0) ? StWait : StCyc;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign viol_o    = viol_q;
   assign irq_o     = irq_q;
   assign outst_o   = outst_q;
   assign state_o   = state_q;
   assign ack_cnt_o = ack_cnt_q;
   assign err_cnt_o = err_cnt_q;
   assign rty_cnt_o = rty_cnt_q;

endmodule

// File: tb/tb_wb_tgt_pchk.sv
// Scoreboard bench for wb_tgt_pchk: default instance plus a MAX_OUT=2 instance on shared inputs.
module tb_wb_tgt_pchk;

   logic clk = 1'b0;
   logic rst, cyc, stb, stall, ack, err, rty, clr;

   logic [5:0]  viol,  viol2;
   logic        irq,   irq2;
   logic [3:0]  outst, outst2;
   logic [1:0]  state, state2;
   logic [15:0] ackc, errc, rtyc, ackc2, errc2, rtyc2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   wb_tgt_pchk dut (
      .clk_i(clk), .sync_rst_i(rst), .tgt_cyc_o(cyc), .tgt_stb_o(stb), .tgt_stall_i(stall),
      .tgt_ack_i(ack), .tgt_err_i(err), .tgt_rty_i(rty), .clr_i(clr),
      .viol_o(viol), .irq_o(irq), .outst_o(outst), .state_o(state),
      .ack_cnt_o(ackc), .err_cnt_o(errc), .rty_cnt_o(rtyc)
   );

   wb_tgt_pchk #(.MAX_OUT(2)) dut2 (
      .clk_i(clk), .sync_rst_i(rst), .tgt_cyc_o(cyc), .tgt_stb_o(stb), .tgt_stall_i(stall),
      .tgt_ack_i(ack), .tgt_err_i(err), .tgt_rty_i(rty), .clr_i(clr),
      .viol_o(viol2), .irq_o(irq2), .outst_o(outst2), .state_o(state2),
      .ack_cnt_o(ackc2), .err_cnt_o(errc2), .rty_cnt_o(rtyc2)
   );

   localparam int SViol = 0, SIrq = 1, SOut = 2, SState = 3, SAck = 4, SErr = 5, SRty = 6;
   localparam int SViol2 = 7, SIrq2 = 8, SOut2 = 9;

   function automatic logic [31:0] observe(int sel);
      case (sel)
         SViol:   return 32'(viol);
         SIrq:    return 32'(irq);
         SOut:    return 32'(outst);
         SState:  return 32'(state);
         SAck:    return 32'(ackc);
         SErr:    return 32'(errc);
         SRty:    return 32'(rtyc);
         SViol2:  return 32'(viol2);
         SIrq2:   return 32'(irq2);
         SOut2:   return 32'(outst2);
         default: return 32'hdead_beef;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic exp_push(input string tag, input int sel, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      sb.push_back(e);
   endtask

   // Advance one edge, then retire every expectation queued for it.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, observe(e.sel), e.val);
      end
   endtask

   task automatic drive(input logic c, input logic s, input logic a, input logic e,
                        input logic r, input logic cl);
      cyc = c; stb = s; ack = a; err = e; rty = r; clr = cl;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      stall = 1'b0;
      rst   = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      exp_push("rst_viol", SViol, 0);   exp_push("rst_irq", SIrq, 0);
      exp_push("rst_outst", SOut, 0);   exp_push("rst_state", SState, 0);
      exp_push("rst_ack", SAck, 0);     exp_push("rst_err", SErr, 0);
      exp_push("rst_rty", SRty, 0);     exp_push("rst_viol2", SViol2, 0);
      tick();
      rst = 1'b0;

      // Three back-to-back requests, then three acks; dut2 overflows at depth 2.
      drive(1, 0, 0, 0, 0, 0); exp_push("s1_state_cyc", SState, 1); tick();
      drive(1, 1, 0, 0, 0, 0); exp_push("s1_out1", SOut, 1); exp_push("s1_state_wait", SState, 2);
      tick();
      drive(1, 1, 0, 0, 0, 0); exp_push("s1_out2", SOut, 2); tick();
      drive(1, 1, 0, 0, 0, 0); exp_push("s1_out3", SOut, 3);
      exp_push("s2_ovf_viol", SViol2, 6'b000100); exp_push("s2_ovf_out", SOut2, 2);
      exp_push("s2_irq_lag", SIrq2, 0);
      tick();
      drive(1, 0, 0, 0, 0, 0); exp_push("s1_hold3", SOut, 3); exp_push("s2_irq", SIrq2, 1);
      exp_push("s2_hold", SOut2, 2);
      tick();
      drive(1, 0, 1, 0, 0, 0); exp_push("s1_dn2", SOut, 2); tick();
      drive(1, 0, 1, 0, 0, 0); exp_push("s1_dn1", SOut, 1); exp_push("s2_dn0", SOut2, 0); tick();
      drive(1, 0, 1, 0, 0, 0); exp_push("s1_dn0", SOut, 0); exp_push("s1_ackc", SAck, 3);
      exp_push("s1_viol", SViol, 0); exp_push("s1_state_back", SState, 1);
      exp_push("s2_spur", SViol2, 6'b000110);
      tick();
      drive(0, 0, 0, 0, 0, 0); exp_push("s1_idle", SState, 0); tick();

      // Timeout after 200 silent cycles, then an err closes it.
      do_reset();
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 1; i < 199; i++) tick();
      exp_push("to_before", SViol, 0); exp_push("to_wait", SState, 2); tick();
      exp_push("to_flag", SViol, 6'b010000); exp_push("to_state", SState, 3); tick();
      drive(1, 0, 0, 1, 0, 0);
      exp_push("to_errc", SErr, 1); exp_push("to_out0", SOut, 0); exp_push("to_cyc", SState, 1);
      exp_push("to_irq", SIrq, 1);
      tick();

      // Multiple termination, spurious ack, then a retry count.
      do_reset();
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 0, 0, 0); tick();
      drive(1, 0, 1, 1, 0, 0);
      exp_push("mt_viol", SViol, 6'b000001); exp_push("mt_ack", SAck, 1);
      exp_push("mt_err", SErr, 1); exp_push("mt_out", SOut, 0);
      tick();
      drive(1, 0, 1, 0, 0, 0);
      exp_push("sp_viol", SViol, 6'b000011); exp_push("sp_out", SOut, 0);
      exp_push("sp_ack", SAck, 1);
      tick();
      drive(1, 1, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 1, 0); exp_push("rty_cnt", SRty, 1); tick();

      // Cycle dropped with two outstanding, then stb without cyc.
      do_reset();
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 0, 0, 0); exp_push("cd_out2", SOut, 2); tick();
      drive(0, 0, 0, 0, 0, 0);
      exp_push("cd_viol", SViol, 6'b001000); exp_push("cd_out", SOut, 0);
      exp_push("cd_state", SState, 0);
      tick();
      drive(0, 1, 0, 0, 0, 0); exp_push("snc_viol", SViol, 6'b101000); tick();

      // Clear coinciding with a spurious ack, then reset in WAIT.
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 0, 0, 0); tick();
      drive(1, 0, 1, 0, 0, 0); exp_push("cl_ack1", SAck, 1); tick();
      drive(1, 0, 1, 0, 0, 1);
      exp_push("cl_viol", SViol, 6'b000010); exp_push("cl_ack0", SAck, 0);
      exp_push("cl_err0", SErr, 0);
      tick();
      drive(1, 1, 0, 0, 0, 0); exp_push("mw_state", SState, 2); tick();
      rst = 1'b1;
      exp_push("mr_viol", SViol, 0); exp_push("mr_irq", SIrq, 0);
      exp_push("mr_out", SOut, 0);   exp_push("mr_state", SState, 0);
      exp_push("mr_ack", SAck, 0);
      tick();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_tgt_pchk.md
Name: wb_tgt_pchk

Overview:
Synthesizable pipelined Wishbone protocol checker for one target interface. It is the hardware successor of the simulation-only target assertion monitor. It passively snoops the target-side bus, tracks outstanding pipelined requests up to a parametrised depth, and detects response timeouts. It reports protocol violations as sticky flags plus an interrupt, and keeps saturating ack/err/rty statistics counters. It sits beside any crossbar target port and drives nothing on the bus.

Parameters:
MAX_OUT, 8, maximum legal outstanding requests (1..2**OUT_WIDTH-1)
OUT_WIDTH, 4, width of outstanding counter
TIMEOUT, 200, cycles without response while requests are outstanding before the timeout flag sets (1..2**TO_WIDTH-1)
TO_WIDTH, 8, width of timeout timer
STAT_WIDTH, 16, width of each statistics counter

Ports:
clk_i  in  1  module clock
sync_rst_i  in  1  synchronous reset, active high
tgt_cyc_o  in  1  snooped bus cycle indicator
tgt_stb_o  in  1  snooped access request
tgt_stall_i  in  1  snooped access delay
tgt_ack_i  in  1  snooped acknowledge
tgt_err_i  in  1  snooped error
tgt_rty_i  in  1  snooped retry
clr_i  in  1  clear sticky flags and statistics
viol_o  out  6  sticky violation flags
irq_o  out  1  registered OR of viol_o
outst_o  out  OUT_WIDTH  current outstanding request count
state_o  out  2  FSM state
ack_cnt_o  out  STAT_WIDTH  acknowledged transfers, saturating
err_cnt_o  out  STAT_WIDTH  error-terminated transfers, saturating
rty_cnt_o  out  STAT_WIDTH  retry-terminated transfers, saturating

Behaviour:
- Single clock domain. Reset is synchronous and active high (clk_i, sync_rst_i).
- On reset, all outputs and internal registers are 0 and the state is IDLE (2'b00). Reset mid-operation discards all tracking.
- Definitions:
  - req = cyc & stb & ~stall.
  - rsp = ack | err | rty.
  - A request accepted in cycle N can be answered no earlier than cycle N+1.
- Outstanding counter next value:
  - If ~cyc: 0.
  - Otherwise: outst + req − (rsp & outst!=0), clamped to 0..MAX_OUT.
  - outst_o is registered, so it is visible one cycle after the accepting or terminating edge.
- Violation flags (set on the edge after the condition, sticky until clr_i or reset):
  - [0] MULTI_TERM: more than one of ack/err/rty is high.
  - [1] SPURIOUS: rsp while outst==0, including rsp while ~cyc. The counter does not decrement.
  - [2] OVERFLOW: req while outst==MAX_OUT and no rsp. The counter holds at MAX_OUT.
  - [3] CYC_DROP: cyc falls while outst!=0. The counter clears to 0.
  - [4] TIMEOUT: timer reaches TIMEOUT.
  - [5] STB_NO_CYC: stb high while cyc is low.
- Timeout timer:
  - Increments each cycle while outst!=0 and ~rsp.
  - Clears on rsp, when outst==0, or when ~cyc.
  - Saturates at TIMEOUT.
- Statistics counters:
  - Each increments on the corresponding termination only when it is non-spurious and cyc is high. On MULTI_TERM, every asserted line counts.
  - Counters saturate at all-ones.
- clr_i zeroes viol_o and all statistics counters; outst and the FSM are unaffected. If clr_i and a new violation or count event coincide, the new event wins: the flag ends set, or the counter ends at 1.
- irq_o = |viol_o, registered, so it lags viol_o by one cycle.
- FSM:
  - IDLE(00) → CYC(01) when cyc.
  - CYC → WAIT(10) on req.
  - WAIT → CYC when the counter next value is 0 and cyc is high.
  - WAIT → TOUT(11) when the timer reaches TIMEOUT.
  - TOUT → WAIT on a rsp that leaves the counter non-zero; TOUT → CYC on a rsp that brings it to 0.
  - Any state → IDLE when ~cyc. This takes priority over all other transitions.
- Simultaneous req and rsp: the count is unchanged and the timer clears.

Test Plan:
- Three back-to-back reqs (stall=0), acks 2, 3 and 4 cycles later → outst_o goes 1,2,3 then down to 0; ack_cnt_o=3; viol_o=0; state sequence IDLE,CYC,WAIT,CYC.
- MAX_OUT=2 with three reqs before any ack → viol_o[2]=1, outst_o holds at 2, irq_o=1 one cycle after viol_o[2].
- One req, then no response for 200 cycles → viol_o[4] sets on the 200th stall cycle and state=TOUT. A later err gives err_cnt_o=1, outst_o=0 and state=CYC.
- ack and err together with outst=1 → viol_o[0]=1, ack_cnt_o=1, err_cnt_o=1. An ack with outst=0 sets viol_o[1], outst_o stays 0, and ack_cnt_o does not increment.
- Two outstanding requests, then cyc drops → viol_o[3]=1, outst_o=0, state=IDLE. stb=1 with cyc=0 sets viol_o[5].
- clr_i coinciding with a new SPURIOUS → viol_o=6'b000010 and counters 0. Asserting sync_rst_i mid-WAIT → all outputs 0 on the next edge.
